// File: rtl/bin_to_bcd_7seg_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_7seg_seq
// Function : Serial double-dabble binary-to-BCD converter driving N active-low
//            7-segment digits, one input bit per clock.
// Options  : define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_7seg_seq #(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [4*N-1:0]   bcd_out,
  output logic [7*N-1:0]   hex_out
);

  localparam int             CW      = $clog2(W + 1);
  localparam logic [CW-1:0]  C_W     = CW'(W);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);
  localparam logic [0:0]     S_IDLE  = 1'b0;
  localparam logic [0:0]     S_SHIFT = 1'b1;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Overflow dashes win over blanking; digit 0 is never blanked.
  function automatic logic [7*N-1:0] render(input logic [4*N-1:0] bcd,
                                            input logic           ovf);
    logic [7*N-1:0] r;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      lead = lead && (bcd[4*i +: 4] == 4'd0);
`endif
      if (ovf)
        r[7*i +: 7] = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
      else if (lead && (i > 0))
        r[7*i +: 7] = 7'b1111111;
`endif
      else
        r[7*i +: 7] = seg7(bcd[4*i +: 4]);
    end
    return r;
  endfunction

  logic [0:0]     state_q,   state_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic [W-1:0]   shift_q,   shift_d;
  logic [4*N-1:0] scratch_q, scratch_d;
  logic           ovf_q,     ovf_d;
  logic           done_q,    done_d;
  logic           overflow_q, overflow_d;
  logic [4*N-1:0] bcd_q,     bcd_d;
  logic [7*N-1:0] hex_q,     hex_d;

  logic [4*N-1:0] adj;
  logic [4*N-1:0] scratch_sh;
  logic           ovf_sh;

  for (genvar i = 0; i < N; i++) begin : g_add3
    assign adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ?
                           (scratch_q[4*i +: 4] + 4'd3) : scratch_q[4*i +: 4];
  end

  // A carry out of the top digit means the value no longer fits in N digits.
  assign scratch_sh = {adj[4*N-2:0], shift_q[W-1]};
  assign ovf_sh     = ovf_q | adj[4*N-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    bcd_d      = bcd_q;
    hex_d      = hex_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = C_W;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d   = shift_q << 1;
        scratch_d = scratch_sh;
        ovf_d     = ovf_sh;
        cnt_d     = cnt_q - C_ONE;
        if (cnt_q == C_ONE) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          overflow_d = ovf_sh;
          bcd_d      = scratch_sh;
          hex_d      = render(scratch_sh, ovf_sh);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= '0;
      hex_q      <= render('0, 1'b0);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      bcd_q      <= bcd_d;
      hex_q      <= hex_d;
    end
  end

  assign busy     = (state_q == S_SHIFT);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign bcd_out  = bcd_q;
  assign hex_out  = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_7seg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_7seg_seq
// Function : Scoreboard bench for bin_to_bcd_7seg_seq (W=8 with N=3 and N=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_7seg_seq;

  localparam int W = 8;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef struct {
    logic [11:0] bcd;
    logic        chk;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start0, start1;
  logic [7:0]  bin0, bin1;
  logic        busy0, done0, ovf0;
  logic        busy1, done1, ovf1;
  logic [11:0] bcd0;
  logic [20:0] hex0;
  logic [7:0]  bcd1;
  logic [13:0] hex1;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [20:0] hx0, hx1;

  bin_to_bcd_7seg_seq #(.W(W), .N(3)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .bin_in(bin0),
    .busy(busy0), .done(done0), .overflow(ovf0),
    .bcd_out(bcd0), .hex_out(hex0)
  );

  bin_to_bcd_7seg_seq #(.W(W), .N(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .bin_in(bin1),
    .busy(busy1), .done(done1), .overflow(ovf1),
    .bcd_out(bcd1), .hex_out(hex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] exp_hex(input logic [11:0] bcd,
                                          input logic ovf, input int nd);
    logic [20:0] r;
    logic        lead;
    logic [3:0]  d;
    r    = '0;
    lead = 1'b1;
    for (int i = nd - 1; i >= 0; i--) begin
      d    = bcd[4*i +: 4];
      lead = lead && (d == 4'd0);
      if (ovf)                          r[7*i +: 7] = 7'b0111111;
      else if (BLANK_EN && lead && i > 0) r[7*i +: 7] = 7'b1111111;
      else                              r[7*i +: 7] = seg_ref(d);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(posedge clk) begin
    #1;
    if (done0) begin
      if (q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut0 unexpected done: got done=1, required no done (cycle %0d)", cyc);
      end else begin
        e0  = q0.pop_front();
        hx0 = exp_hex(e0.bcd, e0.ovf, 3);
        if (e0.chk) check("dut0 bcd_out", 32'(bcd0), 32'(e0.bcd));
        check("dut0 overflow", 32'(ovf0), 32'(e0.ovf));
        check("dut0 hex_out", 32'(hex0), 32'(hx0));
        check("dut0 latency", 32'(cyc - e0.acc), 32'(W));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut1 unexpected done: got done=1, required no done (cycle %0d)", cyc);
      end else begin
        e1  = q1.pop_front();
        hx1 = exp_hex(e1.bcd, e1.ovf, 2);
        if (e1.chk) check("dut1 bcd_out", 32'(bcd1), 32'(e1.bcd[7:0]));
        check("dut1 overflow", 32'(ovf1), 32'(e1.ovf));
        check("dut1 hex_out", 32'(hex1), 32'(hx1[13:0]));
        check("dut1 latency", 32'(cyc - e1.acc), 32'(W));
      end
    end
  end

  task automatic wait_idle(input int which);
    int t = 0;
    while (((which == 0) ? busy0 : busy1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if ((which == 0) ? busy0 : busy1) begin
      n_cmp++; n_err++;
      $display("FAIL dut%0d busy timeout: got busy=1, required busy=0", which);
    end
  endtask

  task automatic drain(input int which);
    int t = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (((which == 0) ? q0.size() : q1.size()) != 0) begin
      n_cmp++; n_err++;
      $display("FAIL dut%0d done timeout: got no done, required %0d pending", which,
               (which == 0) ? q0.size() : q1.size());
      if (which == 0) q0.delete(); else q1.delete();
    end
    repeat (W + 2) @(negedge clk);
  endtask

  task automatic go0(input logic [7:0] v, input logic [11:0] eb);
    wait_idle(0);
    bin0   = v;
    start0 = 1'b1;
    q0.push_back('{eb, 1'b1, 1'b0, cyc + 1});
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic go1(input logic [7:0] v, input logic [11:0] eb,
                     input logic ov, input logic chk);
    wait_idle(1);
    bin1   = v;
    start1 = 1'b1;
    q1.push_back('{eb, chk, ov, cyc + 1});
    @(negedge clk);
    start1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; bin0 = '0; bin1 = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset done", 32'(done0), 32'd0);
    check("reset overflow", 32'(ovf0), 32'd0);
    check("reset bcd_out", 32'(bcd0), 32'd0);
    check("reset hex_out", 32'(hex0), 32'(exp_hex(12'h000, 1'b0, 3)));
    reset = 1'b0;
    @(negedge clk);

    go0(8'd255, 12'h255);
    drain(0);
    check("bcd hold idle", 32'(bcd0), 32'h255);
    go0(8'd7, 12'h007);
    check("bcd hold busy", 32'(bcd0), 32'h255);
    drain(0);
    go0(8'd0, 12'h000);
    drain(0);

    // Second start lands while busy and must be ignored.
    go0(8'd42, 12'h042);
    @(negedge clk);
    bin0 = 8'd13; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; bin0 = 8'd0;
    drain(0);

    // start held high: accepts every W+1 cycles, bin_in wiggles mid-flight.
    wait_idle(0);
    bin0 = 8'd200; start0 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      q0.push_back('{12'h200, 1'b1, 1'b0, cyc + 1});
      if (r == 2) begin
        @(negedge clk);
        start0 = 1'b0;
      end else begin
        repeat (3) @(negedge clk);
        bin0 = 8'd55;
        repeat (W - 2) @(negedge clk);
        bin0 = 8'd200;
      end
    end
    drain(0);

    // Abort a conversion with reset four cycles in.
    wait_idle(0);
    bin0 = 8'd200; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(busy0), 32'd0);
    check("abort done", 32'(done0), 32'd0);
    check("abort bcd_out", 32'(bcd0), 32'd0);
    check("abort overflow", 32'(ovf0), 32'd0);
    check("abort hex_out", 32'(hex0), 32'(exp_hex(12'h000, 1'b0, 3)));
    repeat (W + 2) @(negedge clk);
    go0(8'd128, 12'h128);
    drain(0);

    go1(8'd100, 12'h000, 1'b1, 1'b0);
    drain(1);
    check("dut1 overflow hold", 32'(ovf1), 32'd1);
    go1(8'd99, 12'h099, 1'b0, 1'b1);
    drain(1);
    go1(8'd255, 12'h055, 1'b1, 1'b0);
    drain(1);
    go1(8'd5, 12'h005, 1'b0, 1'b1);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
